// File: rtl/anchor_sched_pkg.sv
// Shared types and geometry constants for the anchor scheduler.
// Window: MARGIN columns left of the anchor plus READ_WIN-MARGIN columns from it.
package anchor_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FLUSH,
        S_FWAIT,
        S_DONE
    } state_t;

    localparam int READ_WIN    = 20;
    localparam int WRITE_STRIP = 10;
    localparam int MARGIN      = 5;
    localparam int MAX_WIDTH   = 4096;

    // Bytes of the output strip that start at column x and stay inside the image.
    function automatic logic [4:0] strip_len(input logic [15:0] w, input logic [15:0] x);
        logic [15:0] rem;
        rem = w - x;
        return (rem > 16'(WRITE_STRIP)) ? 5'(WRITE_STRIP) : 5'(rem);
    endfunction

endpackage

// File: rtl/window_clip.sv
// Clips the read window around an anchor column to the image row.
module window_clip
    import anchor_sched_pkg::*;
(
    input  logic [15:0] anchor_x,
    input  logic [15:0] width,
    output logic [15:0] left,
    output logic [4:0]  length
);

    logic [16:0] reach;
    logic [16:0] last_col;
    logic [15:0] right;

    always_comb begin
        reach    = {1'b0, anchor_x} + 17'(READ_WIN - MARGIN - 1);
        last_col = {1'b0, width} - 17'd1;
        left     = (anchor_x >= 16'(MARGIN)) ? anchor_x - 16'(MARGIN) : 16'd0;
        right    = (reach > last_col) ? last_col[15:0] : reach[15:0];
        length   = 5'(right - left + 16'd1);
    end

endmodule

// File: rtl/anchor_scheduler.sv
// Walks strip anchors across an image, issuing a read window and the write of the previous strip.
// Optional ANCHOR_SCHED_CFG_ERR_EN adds a cfg_err output and rejects width > MAX_WIDTH.
module anchor_scheduler
    import anchor_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_filter,
    input  logic [15:0] width,
    input  logic [15:0] height,
    input  logic [31:0] in_start_address,
    input  logic [31:0] out_start_address,
    input  logic        io_final,
    input  logic        dp_ready,
    output logic [15:0] anchor_x,
    output logic [15:0] anchor_y,
    output logic        anchor_moving,
    output logic [31:0] read_start_address,
    output logic [4:0]  read_length,
    output logic [31:0] write_start_address,
    output logic [4:0]  write_length,
    output logic        busy,
`ifdef ANCHOR_SCHED_CFG_ERR_EN
    output logic        cfg_err,
`endif
    output logic        system_done
);

    state_t      state, state_next;
    logic [15:0] w_r, h_r, ax, ay, px;
    logic [31:0] in_base, out_base, row_base, prev_row_base;
    logic        first_anchor, io_seen, dp_seen;
    logic        cfg_bad, io_any, dp_any, row_wrap, last_anchor;
    logic [16:0] step_x;
    logic [15:0] clip_left;
    logic [4:0]  clip_len;

    window_clip u_clip (
        .anchor_x (ax),
        .width    (w_r),
        .left     (clip_left),
        .length   (clip_len)
    );

    always_comb begin
        cfg_bad = (width == 16'd0) || (height == 16'd0);
`ifdef ANCHOR_SCHED_CFG_ERR_EN
        cfg_bad = cfg_bad || (width > 16'(MAX_WIDTH));
`endif
        io_any      = io_seen | io_final;
        dp_any      = dp_seen | dp_ready;
        step_x      = {1'b0, ax} + 17'(WRITE_STRIP);
        row_wrap    = step_x >= {1'b0, w_r};
        last_anchor = row_wrap && (({1'b0, ay} + 17'd1) >= {1'b0, h_r});
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (en_filter) state_next = cfg_bad ? S_DONE : S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (io_any && dp_any) state_next = last_anchor ? S_FLUSH : S_ISSUE;
            S_FLUSH: state_next = S_FWAIT;
            S_FWAIT: if (io_final) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_r <= '0; h_r <= '0; ax <= '0; ay <= '0; px <= '0;
            in_base <= '0; out_base <= '0; row_base <= '0; prev_row_base <= '0;
            first_anchor <= 1'b0; io_seen <= 1'b0; dp_seen <= 1'b0;
            anchor_x <= '0; anchor_y <= '0; anchor_moving <= 1'b0;
            read_start_address <= '0; read_length <= '0;
            write_start_address <= '0; write_length <= '0;
            busy <= 1'b0; system_done <= 1'b0;
`ifdef ANCHOR_SCHED_CFG_ERR_EN
            cfg_err <= 1'b0;
`endif
        end else begin
            anchor_moving <= 1'b0;
            system_done   <= 1'b0;
            busy          <= (state_next != S_IDLE);
            case (state)
                S_IDLE: if (en_filter) begin
                    w_r <= width; h_r <= height;
                    in_base <= in_start_address; out_base <= out_start_address;
                    ax <= '0; ay <= '0; px <= '0;
                    row_base <= '0; prev_row_base <= '0;
                    first_anchor <= 1'b1; io_seen <= 1'b0; dp_seen <= 1'b0;
`ifdef ANCHOR_SCHED_CFG_ERR_EN
                    cfg_err <= cfg_bad;
`endif
                end
                S_ISSUE: begin
                    anchor_moving       <= 1'b1;
                    anchor_x            <= ax;
                    anchor_y            <= ay;
                    read_start_address  <= in_base + row_base + {16'd0, clip_left};
                    read_length         <= clip_len;
                    // The write trails the read by one anchor: it covers the strip issued last time.
                    write_start_address <= out_base + prev_row_base + {16'd0, px};
                    write_length        <= first_anchor ? 5'd0 : strip_len(w_r, px);
                    px            <= ax;
                    prev_row_base <= row_base;
                    first_anchor  <= 1'b0;
                end
                S_WAIT: begin
                    if (io_any && dp_any) begin
                        io_seen <= 1'b0;
                        dp_seen <= 1'b0;
                        if (!last_anchor) begin
                            if (row_wrap) begin
                                ax       <= '0;
                                ay       <= ay + 16'd1;
                                row_base <= row_base + {16'd0, w_r};
                            end else begin
                                ax <= step_x[15:0];
                            end
                        end
                    end else begin
                        io_seen <= io_any;
                        dp_seen <= dp_any;
                    end
                end
                S_FLUSH: begin
                    read_length         <= '0;
                    write_start_address <= out_base + prev_row_base + {16'd0, px};
                    write_length        <= strip_len(w_r, px);
                end
                S_FWAIT: if (io_final) begin
                    read_length  <= '0;
                    write_length <= '0;
                end
                S_DONE:  system_done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_anchor_scheduler.sv
// Self-checking bench: per-job transaction lists built from the strip rules, randomized handshakes.
module tb_anchor_scheduler;

    logic        clk = 1'b0;
    logic        rst, en_filter, io_final, dp_ready;
    logic [15:0] width, height;
    logic [31:0] in_start_address, out_start_address;
    logic [15:0] anchor_x, anchor_y;
    logic        anchor_moving, busy, system_done;
    logic [31:0] read_start_address, write_start_address;
    logic [4:0]  read_length, write_length;
`ifdef ANCHOR_SCHED_CFG_ERR_EN
    logic        cfg_err;
`endif

    int n_vec = 0, n_err = 0;
    int mv_cnt = 0, done_cnt = 0;

    typedef struct {
        int x; int y;
        logic [31:0] rs; int rl;
        logic [31:0] ws; int wl;
    } txn_t;

    anchor_scheduler dut (
        .clk(clk), .rst(rst), .en_filter(en_filter), .width(width), .height(height),
        .in_start_address(in_start_address), .out_start_address(out_start_address),
        .io_final(io_final), .dp_ready(dp_ready),
        .anchor_x(anchor_x), .anchor_y(anchor_y), .anchor_moving(anchor_moving),
        .read_start_address(read_start_address), .read_length(read_length),
        .write_start_address(write_start_address), .write_length(write_length),
        .busy(busy),
`ifdef ANCHOR_SCHED_CFG_ERR_EN
        .cfg_err(cfg_err),
`endif
        .system_done(system_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (anchor_moving) mv_cnt++;
        if (system_done)   done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // mode: 0 random delays, 1 dp before io, 2 io before dp, 3 simultaneous.
    // ab_x/ab_y: stop right after this anchor is issued (no flush).
    task automatic run_job(input int w, input int h, input logic [31:0] ib, input logic [31:0] ob,
                           input int mode, input int ab_x, input int ab_y);
        txn_t q[$];
        txn_t t;
        int px = 0, py = 0, first = 1;
        int mv0, dn0, dio, ddp, k, fwl;
        logic [31:0] fws;
        bit got;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x += 10) begin
                int lft, rgt;
                lft  = (x >= 5) ? x - 5 : 0;
                rgt  = (x + 14 < w - 1) ? x + 14 : w - 1;
                t.x  = x; t.y = y;
                t.rl = rgt - lft + 1;
                t.rs = ib + 32'(y * w) + 32'(lft);
                t.ws = ob + (first ? 32'd0 : 32'(py * w) + 32'(px));
                t.wl = first ? 0 : ((w - px < 10) ? w - px : 10);
                q.push_back(t);
                px = x; py = y; first = 0;
            end
        end
        fws = ob + 32'(py * w) + 32'(px);
        fwl = (w - px < 10) ? w - px : 10;

        mv0 = mv_cnt; dn0 = done_cnt;
        @(negedge clk);
        width = 16'(w); height = 16'(h);
        in_start_address = ib; out_start_address = ob; en_filter = 1'b1;
        @(negedge clk);
        en_filter = 1'b0;
        for (int idx = 0; idx < q.size(); idx++) begin
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                got = anchor_moving;
            end
            n_vec++;
            if (!got) begin
                n_err++;
                $display("FAIL issue_timeout: no anchor_moving, required anchor (%0d,%0d)", q[idx].x, q[idx].y);
                return;
            end
            n_vec++;
            if (anchor_x !== 16'(q[idx].x) || anchor_y !== 16'(q[idx].y) ||
                read_start_address !== q[idx].rs || read_length !== 5'(q[idx].rl) ||
                write_start_address !== q[idx].ws || write_length !== 5'(q[idx].wl)) begin
                n_err++;
                $display("FAIL issue_fields w=%0d: got (%0d,%0d) rd %0h/%0d wr %0h/%0d, expected (%0d,%0d) rd %0h/%0d wr %0h/%0d",
                         w, anchor_x, anchor_y, read_start_address, read_length, write_start_address, write_length,
                         q[idx].x, q[idx].y, q[idx].rs, q[idx].rl, q[idx].ws, q[idx].wl);
            end
            if (q[idx].x == ab_x && q[idx].y == ab_y) return;
            case (mode)
                0: begin dio = $urandom_range(0, 3); ddp = $urandom_range(0, 3); end
                1: begin dio = 2; ddp = 0; end
                2: begin dio = 0; ddp = 2; end
                default: begin dio = 0; ddp = 0; end
            endcase
            k = (dio > ddp) ? dio : ddp;
            for (int c = 0; c <= k; c++) begin
                io_final = (c == dio);
                dp_ready = (c == ddp);
                @(negedge clk);
                if (c < k) begin
                    n_vec++;
                    if (anchor_moving !== 1'b0) begin
                        n_err++;
                        $display("FAIL early_advance: anchor_moving=%b before both handshakes, expected 0", anchor_moving);
                    end
                end
            end
            io_final = 1'b0; dp_ready = 1'b0;
        end

        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            got = (read_length == 5'd0);
        end
        n_vec++;
        if (!got || write_start_address !== fws || write_length !== 5'(fwl) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL flush_write: got rd_len %0d wr %0h/%0d busy %b, expected rd_len 0 wr %0h/%0d busy 1",
                     read_length, write_start_address, write_length, busy, fws, fwl);
        end
        dp_ready = 1'b1;
        @(negedge clk);
        dp_ready = 1'b0;
        n_vec++;
        if (write_length !== 5'(fwl) || system_done !== 1'b0) begin
            n_err++;
            $display("FAIL fwait_dp_ignored: got wr_len %0d done %b, expected wr_len %0d done 0",
                     write_length, system_done, fwl);
        end
        io_final = 1'b1;
        @(negedge clk);
        io_final = 1'b0;
        n_vec++;
        if (read_length !== 5'd0 || write_length !== 5'd0) begin
            n_err++;
            $display("FAIL done_lengths: got rd %0d wr %0d, expected 0 0", read_length, write_length);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (done_cnt - dn0 != 1 || mv_cnt - mv0 != q.size() || busy !== 1'b0) begin
            n_err++;
            $display("FAIL job_counts w=%0d h=%0d: got done %0d moves %0d busy %b, expected done 1 moves %0d busy 0",
                     w, h, done_cnt - dn0, mv_cnt - mv0, busy, q.size());
        end
    endtask

    task automatic start_bad(input int w, input int h, input bit expect_err);
        int mv0, dn0;
        bit seen = 1'b0;
        mv0 = mv_cnt; dn0 = done_cnt;
        @(negedge clk);
        width = 16'(w); height = 16'(h); en_filter = 1'b1;
        @(negedge clk);
        en_filter = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            seen |= system_done;
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (!seen || done_cnt - dn0 != 1 || mv_cnt != mv0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bad_start w=%0d h=%0d: got done_seen %b done %0d moves %0d busy %b, expected 1 1 0 0",
                     w, h, seen, done_cnt - dn0, mv_cnt - mv0, busy);
        end
`ifdef ANCHOR_SCHED_CFG_ERR_EN
        n_vec++;
        if (cfg_err !== expect_err) begin
            n_err++;
            $display("FAIL cfg_err w=%0d h=%0d: got %b, expected %b", w, h, cfg_err, expect_err);
        end
`else
        if (expect_err) ;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({anchor_x, anchor_y, anchor_moving, read_start_address, read_length,
             write_start_address, write_length, busy, system_done} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got x=%0d y=%0d mv=%b rd %0h/%0d wr %0h/%0d busy=%b done=%b, expected all 0",
                     anchor_x, anchor_y, anchor_moving, read_start_address, read_length,
                     write_start_address, write_length, busy, system_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_image();
        run_job(30, 30, 32'd0, 32'd0, 3, -1, -1);
    endtask

    task automatic test_narrow();
        run_job(25, 3, 32'h0000_1000, 32'h0000_8000, 0, -1, -1);
        run_job(7, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFA, 0, -1, -1);
    endtask

    task automatic test_handshake_order();
        run_job(30, 1, 32'h100, 32'h200, 1, -1, -1);
        run_job(30, 1, 32'h100, 32'h200, 2, -1, -1);
        run_job(30, 1, 32'h100, 32'h200, 3, -1, -1);
    endtask

    task automatic test_zero_dim();
        start_bad(0, 5, 1'b1);
        start_bad(10, 0, 1'b1);
`ifdef ANCHOR_SCHED_CFG_ERR_EN
        start_bad(4097, 1, 1'b1);
        run_job(12, 1, 32'h40, 32'h80, 0, -1, -1);
        n_vec++;
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_err_clear: got %b, expected 0", cfg_err);
        end
`else
        run_job(4097, 1, 32'h10, 32'h20, 3, -1, -1);
`endif
    endtask

    task automatic test_reset_midjob();
        run_job(30, 30, 32'h0, 32'h0, 3, 10, 3);
        io_final = 1'b1;
        @(negedge clk);
        io_final = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({anchor_x, anchor_y, anchor_moving, read_start_address, read_length,
             write_start_address, write_length, busy, system_done} !== '0) begin
            n_err++;
            $display("FAIL midjob_reset: got x=%0d y=%0d mv=%b rd %0h/%0d wr %0h/%0d busy=%b done=%b, expected all 0",
                     anchor_x, anchor_y, anchor_moving, read_start_address, read_length,
                     write_start_address, write_length, busy, system_done);
        end
        rst = 1'b0;
        run_job(30, 4, $urandom, $urandom, 1, -1, -1);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(1, 45), $urandom_range(1, 4), $urandom, $urandom, 0, -1, -1);
    endtask

    initial begin
        rst = 1'b1; en_filter = 1'b0; io_final = 1'b0; dp_ready = 1'b0;
        width = '0; height = '0; in_start_address = '0; out_start_address = '0;
        test_reset();
        test_full_image();
        test_narrow();
        test_handshake_order();
        test_zero_dim();
        test_reset_midjob();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/anchor_scheduler.md
ANCHOR_SCHEDULER -- requirements
Module: anchor_scheduler

Interface
REQ-001: clk  in  1  system clock; all state updates on rising edge.
REQ-002: rst  in  1  reset; synchronous, active-high.
REQ-003: en_filter  in  1  start request; sampled only in IDLE.
REQ-004: width, height  in  16 each  image dimensions in pixels.
REQ-005: in_start_address, out_start_address  in  32 each  image base byte addresses.
REQ-006: io_final  in  1  memory side reports the current read/write transaction complete.
REQ-007: dp_ready  in  1  edge datapath has consumed the current window.
REQ-008: anchor_x, anchor_y  out  16 each  current strip anchor (column, row).
REQ-009: anchor_moving  out  1  one-cycle pulse when a new anchor is issued.
REQ-010: read_start_address  out  32, read_length  out  5  read window, at most 20 bytes.
REQ-011: write_start_address  out  32, write_length  out  5  write strip, at most 10 bytes; 0 means no write.
REQ-012: busy  out  1  high in every state except IDLE.
REQ-013: system_done  out  1  one-cycle completion pulse.

Function
REQ-014: FSM states SHALL be IDLE, ISSUE, WAIT, FLUSH, FWAIT and DONE; all outputs SHALL be registered.
REQ-015: IDLE with en_filter=1 SHALL latch width, height and both base addresses, set anchor to (0,0), clear row bases, and enter ISSUE on the next cycle.
REQ-016: en_filter outside IDLE SHALL be ignored.
REQ-017: ISSUE SHALL assert anchor_moving for exactly one cycle, drive the read/write fields, and enter WAIT on the next cycle.
REQ-018: Read window: left=max(anchor_x-5,0); right=min(anchor_x+14,width-1); read_length=right-left+1; read_start_address=in_start_address+row_in_base+left.
REQ-019: Write strip SHALL address the previously issued anchor (px,py): write_start_address=out_start_address+row_out_base(py)+px; write_length=min(10,width-px); write_length=0 for the first anchor of a job.
REQ-020: WAIT SHALL latch io_final and dp_ready independently, in any order or simultaneously, and advance only once both have been seen; the latches SHALL clear on advance.
REQ-021: Advance SHALL set anchor_x+=10; if the new anchor_x>=width, anchor_x SHALL become 0, anchor_y SHALL increment, and row_in_base SHALL increment by width; on the last anchor the FSM SHALL go to FLUSH instead of advancing; otherwise it SHALL return to ISSUE.
REQ-022: Row bases SHALL be kept as 32-bit running sums of width; no multiplier is permitted; additions SHALL wrap modulo 2^32.
REQ-023: FLUSH SHALL issue read_length=0 with a write for the last anchor, then wait for io_final in FWAIT, ignoring dp_ready.
REQ-024: DONE SHALL pulse system_done for one cycle and then return to IDLE.
REQ-025: A start with width=0 or height=0 SHALL go directly to DONE with no transaction issued.
REQ-026: read_length and write_length SHALL hold their values through WAIT and FWAIT, and SHALL be 0 in IDLE and DONE.

Reset
REQ-027: rst=1 SHALL force IDLE and zero every output and internal register on the next edge, including mid-job; any pending handshake latch SHALL be discarded.

Configuration
REQ-028: With ANCHOR_SCHED_CFG_ERR_EN defined, an extra output cfg_err (1 bit) SHALL be present; it SHALL be set when a start has width=0, height=0, or width>4096; it SHALL remain set until the next accepted start; an erroneous start SHALL go straight to DONE.
REQ-029: Without the macro, the cfg_err port SHALL be absent and width>4096 SHALL be accepted unchecked.

Structure
REQ-030: Package anchor_sched_pkg SHALL hold the state enum, READ_WIN=20, WRITE_STRIP=10, MARGIN=5 and MAX_WIDTH=4096.
REQ-031: The window clip arithmetic (left, right, length) SHALL be one combinational sub-module, window_clip.

Verification
REQ-032: 30x30, both bases 0, start -> first ISSUE gives read 0/15 and write length 0; anchor (10,0) gives read 5/20 and write 0/10; anchor (20,0) gives read 15/15.
REQ-033: Same job, io_final and dp_ready asserted the cycle after every ISSUE -> 90 anchor_moving pulses, final FLUSH write 890/10, then exactly one system_done pulse.
REQ-034: width=25 -> anchor (20,y) read length 10 and its later write length 5.
REQ-035: dp_ready two cycles before io_final, then the reverse, then both in the same cycle -> each case advances exactly once.
REQ-036: rst pulsed during WAIT of anchor (10,3) -> next cycle IDLE, all outputs 0; a fresh en_filter restarts at (0,0).
REQ-037: ANCHOR_SCHED_CFG_ERR_EN defined, start with width=0 -> cfg_err=1, no anchor_moving, system_done within 2 cycles.
